conv_obuf: RTL and testbench

CONV_OBUF -- requirements
Module: conv_obuf

---
 rtl/conv_obuf.sv | 195 +++++++++++++++++++
 tb/tb_conv_obuf.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_obuf.sv
// ----------------------------------------------------------------------------
// conv_obuf -- output buffer for a bit-serial convolution crossbar.
//
// The crossbar delivers one signed partial sum per output channel per
// activation bit ("beat"), LSB first. This block weights each beat by its bit
// position, accumulates DATA_SIZE beats into one pixel, then requantizes
// (arithmetic right shift, ReLU, saturate to DATA_SIZE bits) and strobes the
// pixel into the next layer's input buffer one cycle after the last beat.
//
// Ports
//   clk             : rising-edge clock
//   rst             : synchronous, active-high reset
//   i_valid         : a crossbar result beat is present
//   i_count         : activation bit index of the beat (LSB first)
//   i_psum          : OUTPUT_CHANNELS x PSUM_WIDTH signed partial sums,
//                     channel ch at [ch*PSUM_WIDTH +: PSUM_WIDTH]
//   o_ready         : beats are accepted this cycle
//   o_write_enable  : per-channel write strobe, all ones for one cycle/pixel
//   o_data          : OUTPUT_CHANNELS x DATA_SIZE requantized pixel,
//                     channel ch at [ch*DATA_SIZE +: DATA_SIZE]
//   o_pixel_count   : pixels emitted in the current frame
//   o_done          : pulses with the write strobe of the last frame pixel
//   o_error         : sticky sequencing error (out-of-order beat, or beat
//                     offered while emitting)
// ----------------------------------------------------------------------------
module conv_obuf #(
    parameter int DATA_SIZE       = 8,
    parameter int OUTPUT_CHANNELS = 2,
    parameter int PSUM_WIDTH      = 16,
    parameter int SHIFT           = 8,
    parameter int IMG_DIM         = 28,
    parameter int KERNEL_DIM      = 3,
    parameter int COUNT_WIDTH     = (DATA_SIZE == 1) ? 1 : $clog2(DATA_SIZE),
    parameter int ACC_WIDTH       = PSUM_WIDTH + DATA_SIZE + 1,
    parameter int OUT_PIXELS      = (IMG_DIM - KERNEL_DIM + 1) * (IMG_DIM - KERNEL_DIM + 1),
    parameter int PIX_WIDTH       = $clog2(OUT_PIXELS + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_valid,
    input  logic [COUNT_WIDTH-1:0]                i_count,
    input  logic [OUTPUT_CHANNELS*PSUM_WIDTH-1:0] i_psum,
    output logic                                  o_ready,
    output logic [OUTPUT_CHANNELS-1:0]            o_write_enable,
    output logic [OUTPUT_CHANNELS*DATA_SIZE-1:0]  o_data,
    output logic [PIX_WIDTH-1:0]                  o_pixel_count,
    output logic                                  o_done,
    output logic                                  o_error
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] LAST_BIT = COUNT_WIDTH'(DATA_SIZE - 1);
    localparam logic [PIX_WIDTH-1:0]   LAST_PIX = PIX_WIDTH'(OUT_PIXELS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'((64'd1 << DATA_SIZE) - 64'd1);

    // Sign-extend a partial sum to accumulator width and weight it by 2^bit.
    // ACC_WIDTH leaves one spare bit over a full sum of extreme beats, so the
    // running total can never wrap.
    function automatic logic signed [ACC_WIDTH-1:0] weigh_beat(
        input logic signed [PSUM_WIDTH-1:0] p,
        input logic        [COUNT_WIDTH-1:0] bit_idx
    );
        logic signed [ACC_WIDTH-1:0] ext;
        ext = {{(ACC_WIDTH - PSUM_WIDTH){p[PSUM_WIDTH-1]}}, p};
        return ext <<< bit_idx;
    endfunction

    // Requantize: arithmetic shift, clamp negatives to 0 (ReLU), saturate
    // anything above the largest DATA_SIZE-bit code.
    function automatic logic [DATA_SIZE-1:0] requant(
        input logic signed [ACC_WIDTH-1:0] s
    );
        logic signed [ACC_WIDTH-1:0] y;
        y = s >>> SHIFT;
        if (y[ACC_WIDTH-1]) begin
            return '0;
        end else if (y > SAT_MAX) begin
            return '1;
        end else begin
            return y[DATA_SIZE-1:0];
        end
    endfunction

    state_t                             state_q, state_d;
    logic [COUNT_WIDTH-1:0]             exp_bit_q, exp_bit_d;
    logic signed [ACC_WIDTH-1:0]        acc_q [OUTPUT_CHANNELS];
    logic signed [ACC_WIDTH-1:0]        acc_d [OUTPUT_CHANNELS];
    logic signed [ACC_WIDTH-1:0]        sum_c [OUTPUT_CHANNELS];
    logic [OUTPUT_CHANNELS*DATA_SIZE-1:0] data_q, data_d;
    logic [OUTPUT_CHANNELS-1:0]         we_q, we_d;
    logic [PIX_WIDTH-1:0]               pix_q, pix_d;
    logic                               done_q, done_d;
    logic                               error_q, error_d;

    always_comb begin
        state_d   = state_q;
        exp_bit_d = exp_bit_q;
        data_d    = data_q;
        we_d      = '0;
        pix_d     = pix_q;
        done_d    = 1'b0;
        error_d   = error_q;

        for (int ch = 0; ch < OUTPUT_CHANNELS; ch++) begin
            sum_c[ch] = acc_q[ch] +
                        weigh_beat(i_psum[ch*PSUM_WIDTH +: PSUM_WIDTH], i_count);
            acc_d[ch] = acc_q[ch];
        end

        unique case (state_q)
            ST_ACC: begin
                if (i_valid) begin
                    if (i_count == exp_bit_q) begin
                        if (i_count == LAST_BIT) begin
                            // Final beat: capture the pixel now so the strobe
                            // lands exactly one cycle later, and restart the
                            // accumulator for the next pixel.
                            for (int ch = 0; ch < OUTPUT_CHANNELS; ch++) begin
                                data_d[ch*DATA_SIZE +: DATA_SIZE] = requant(sum_c[ch]);
                                acc_d[ch] = '0;
                            end
                            exp_bit_d = '0;
                            we_d      = '1;
                            state_d   = ST_EMIT;
                            if (pix_q == LAST_PIX) begin
                                pix_d  = '0;
                                done_d = 1'b1;
                            end else begin
                                pix_d  = pix_q + PIX_WIDTH'(1);
                            end
                        end else begin
                            for (int ch = 0; ch < OUTPUT_CHANNELS; ch++) begin
                                acc_d[ch] = sum_c[ch];
                            end
                            exp_bit_d = exp_bit_q + COUNT_WIDTH'(1);
                        end
                    end else begin
                        // Out-of-order beat: drop it, keep the partial pixel.
                        error_d = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                state_d = ST_ACC;
                if (i_valid) begin
                    error_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACC;
            exp_bit_q <= '0;
            for (int ch = 0; ch < OUTPUT_CHANNELS; ch++) begin
                acc_q[ch] <= '0;
            end
            data_q    <= '0;
            we_q      <= '0;
            pix_q     <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_bit_q <= exp_bit_d;
            for (int ch = 0; ch < OUTPUT_CHANNELS; ch++) begin
                acc_q[ch] <= acc_d[ch];
            end
            data_q    <= data_d;
            we_q      <= we_d;
            pix_q     <= pix_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // Ready is held low while reset is asserted so no upstream beat is
    // presented as accepted during reset.
    assign o_ready        = (state_q == ST_ACC) && !rst;
    assign o_write_enable = we_q;
    assign o_data         = data_q;
    assign o_pixel_count  = pix_q;
    assign o_done         = done_q;
    assign o_error        = error_q;

endmodule

// File: tb/tb_conv_obuf.sv
// ----------------------------------------------------------------------------
// tb_conv_obuf -- scoreboard bench for conv_obuf (default geometry, 676
// pixels per frame). The driver updates a behavioural pixel model on every
// clock edge and queues expected emissions; a negedge monitor pops the queue
// whenever the DUT strobes a pixel and also checks ready/error/hold state.
// ----------------------------------------------------------------------------
module tb_conv_obuf;

    localparam int DS   = 8;
    localparam int CH   = 2;
    localparam int PW   = 16;
    localparam int SH   = 8;
    localparam int OUTP = 676;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [2:0]  i_count;
    logic [31:0] i_psum;
    logic        o_ready;
    logic [1:0]  o_write_enable;
    logic [15:0] o_data;
    logic [9:0]  o_pixel_count;
    logic        o_done;
    logic        o_error;

    conv_obuf #(
        .DATA_SIZE(DS), .OUTPUT_CHANNELS(CH), .PSUM_WIDTH(PW),
        .SHIFT(SH), .IMG_DIM(28), .KERNEL_DIM(3)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_count(i_count),
        .i_psum(i_psum), .o_ready(o_ready), .o_write_enable(o_write_enable),
        .o_data(o_data), .o_pixel_count(o_pixel_count), .o_done(o_done),
        .o_error(o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        done;
        int          pix;
    } exp_t;

    exp_t sbq[$];

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    int     m_exp;
    longint m_sum0, m_sum1;
    bit     m_emit;
    bit     m_err;
    int     m_pix;
    bit     flush_mon;
    bit     mon_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Pixel value from the full weighted sum: floor-divide by 2^SHIFT, ReLU,
    // saturate to 8 bits.
    function automatic int pixel_of(input longint s);
        longint y;
        y = s >>> SH;
        if (y < 0)   return 0;
        if (y > 255) return 255;
        return int'(y);
    endfunction

    task automatic model_step(input bit r, input bit v, input int cnt, input int p0, input int p1);
        exp_t e;
        if (r) begin
            m_exp = 0; m_sum0 = 0; m_sum1 = 0;
            m_emit = 0; m_err = 0; m_pix = 0;
            flush_mon = 1;
            return;
        end
        if (m_emit) begin
            if (v) m_err = 1;
            m_emit = 0;
            return;
        end
        if (!v) return;
        if (cnt != m_exp) begin
            m_err = 1;
            return;
        end
        m_sum0 += longint'(p0) * (longint'(1) << cnt);
        m_sum1 += longint'(p1) * (longint'(1) << cnt);
        m_exp++;
        if (m_exp == DS) begin
            e.data = {8'(pixel_of(m_sum1)), 8'(pixel_of(m_sum0))};
            m_pix++;
            if (m_pix == OUTP) begin
                e.done = 1'b1;
                m_pix  = 0;
            end else begin
                e.done = 1'b0;
            end
            e.pix = m_pix;
            sbq.push_back(e);
            m_sum0 = 0; m_sum1 = 0; m_exp = 0;
            m_emit = 1;
        end
    endtask

    task automatic drive(input bit r, input bit v, input int cnt, input int p0, input int p1);
        rst     = r;
        i_valid = v;
        i_count = cnt[2:0];
        i_psum  = {p1[15:0], p0[15:0]};
        @(posedge clk);
        model_step(r, v, cnt, p0, p1);
        #1;
    endtask

    task automatic pixel_const(input int p0, input int p1);
        for (int k = 0; k < DS; k++) drive(0, 1, k, p0, p1);
        drive(0, 0, 0, 0, 0);
    endtask

    function automatic int rnd_psum();
        logic signed [15:0] t;
        case ($urandom_range(0, 9))
            0:       return -32768;
            1:       return 32767;
            default: begin
                t = 16'($urandom);
                return int'(t);
            end
        endcase
    endfunction

    // Monitor
    logic [15:0] last_data;
    int          last_pix;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            if (flush_mon) begin
                last_data = '0;
                last_pix  = 0;
                flush_mon = 0;
            end
            check("ready", o_ready, (!rst && !m_emit));
            check("error", o_error, m_err);
            if (o_write_enable !== 2'b00) begin
                check("we_all_ones", o_write_enable, 2'b11);
                if (sbq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_emit: got we=%b, expected no write", o_write_enable);
                end else begin
                    e = sbq.pop_front();
                    check("emit_data", o_data, e.data);
                    check("emit_done", o_done, e.done);
                    check("emit_pix", o_pixel_count, e.pix);
                    last_data = e.data;
                    last_pix  = e.pix;
                end
            end else begin
                check("done_idle", o_done, 0);
                check("data_hold", o_data, last_data);
                check("pix_hold", o_pixel_count, last_pix);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no end of stimulus, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pixels;
        int p0, p1, c;
        mon_en  = 0;
        rst     = 1;
        i_valid = 0;
        i_count = '0;
        i_psum  = '0;
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        mon_en = 1;
        drive(1, 0, 0, 0, 0);   // reset state observed while rst=1
        drive(0, 0, 0, 0, 0);   // ready after release

        // Basic, ReLU and saturation pixels
        pixel_const(3, 3);
        pixel_const(-1, 1000);
        pixel_const(1000, -1);
        pixel_const(-32768, 32767);
        pixel_const(300, 257);

        // Out-of-order beat is dropped, pixel then completes
        drive(0, 1, 0, 3, 3);
        drive(0, 1, 1, 3, 3);
        drive(0, 1, 3, 999, 999);
        for (int k = 2; k < DS; k++) drive(0, 1, k, 3, 3);
        drive(0, 0, 0, 0, 0);

        // Reset mid-accumulation discards the partial pixel
        for (int k = 0; k < 4; k++) drive(0, 1, k, 100, 100);
        drive(1, 0, 0, 0, 0);
        pixel_const(3, 3);

        // Valid held through the emit cycle is ignored
        for (int k = 0; k < DS; k++) drive(0, 1, k, 500, -7);
        drive(0, 1, 0, 50, 50);
        pixel_const(20, 40);

        // Randomised traffic with gaps and sequencing errors
        pixels = 0;
        while (pixels < 40) begin
            if (m_emit) begin
                drive(0, $urandom_range(0, 1), $urandom_range(0, 7), rnd_psum(), rnd_psum());
                pixels++;
            end else if ($urandom_range(0, 5) == 0) begin
                drive(0, 0, $urandom_range(0, 7), rnd_psum(), rnd_psum());
            end else begin
                c = m_exp;
                if ($urandom_range(0, 9) == 0) c = (m_exp + 1 + $urandom_range(0, 6)) % DS;
                p0 = rnd_psum();
                p1 = rnd_psum();
                drive(0, 1, c, p0, p1);
            end
        end

        // Full frame of back-to-back pixels from a clean reset
        drive(1, 0, 0, 0, 0);
        for (int n = 0; n < OUTP; n++) begin
            for (int k = 0; k < DS; k++) drive(0, 1, k, rnd_psum(), rnd_psum());
            drive(0, 0, 0, 0, 0);
        end
        pixel_const(3, 3);   // first pixel of the next frame
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        check("sb_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
